segre_mem_arbiter: RTL and testbench
====================================

# segre_mem_arbiter

Arbitrates line-granular memory requests (`cache_mem_req_t`) from the instruction and data caches onto the single main-memory port. It buffers up to `ARB_BUF_SIZE` requests in a FIFO and issues them to memory one at a time. Read responses are routed back to the originating cache by `cache_id`. It sits between the icache/dcache miss/writeback logic and the memory model.

## Interface
Parameters:
- `BUF_SIZE`, default `segre_pkg::ARB_BUF_SIZE` (16): FIFO depth; must be a power of two.
- `PTR_SIZE`, default `segre_pkg::ARB_PTR_SIZE` (4): FIFO pointer width.
- `LINE_BITS`, default `segre_pkg::CACHE_LINE_SIZE_BITS` (128): response line width.

Ports:
- `clk_i` in 1: single clock. All state changes on the rising edge.
- `rsn_i` in 1: reset. Synchronous, active-low.
- `ic_req_i` in 1: icache request valid.
- `ic_req_data_i` in `cache_mem_req_t`: icache request.
- `ic_ready_o` out 1: icache request accepted this cycle.
- `dc_req_i` in 1: dcache request valid.
- `dc_req_data_i` in `cache_mem_req_t`: dcache request.
- `dc_ready_o` out 1: dcache request accepted this cycle.
- `mem_req_valid_o` out 1: request presented to memory.
- `mem_req_o` out `cache_mem_req_t`: FIFO head entry.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_rsp_valid_i` in 1: memory read data valid.
- `mem_rsp_line_i` in `LINE_BITS`: memory read data.
- `ic_rsp_valid_o` out 1: one-cycle pulse, line for icache.
- `dc_rsp_valid_o` out 1: one-cycle pulse, line for dcache.
- `rsp_line_o` out `LINE_BITS`: registered response line.

## Operation
- **FIFO state:** `head`, `tail` (`PTR_SIZE` bits, natural wrap) and `count` (`PTR_SIZE+1` bits). Full when `count==BUF_SIZE`; empty when `count==0`.
- **Enqueue:** at most one request per cycle.
  - If only one side is valid, that side is granted.
  - If both are valid, grant the side opposite `last_grant` (round-robin). `last_grant` resets to ICACHE, so dcache wins the first tie.
  - `ic_ready_o`/`dc_ready_o` are combinational: high only for the granted side, only when not full, and only when `rsn_i==1`.
  - Entry is stored unchanged; `cache_id` is overwritten with the source port's id.
- **Request type:** `rd==1` means read; `wr` is ignored when `rd==1`. `rd==0` means write (posted, no response).
- **FSM states:** `IDLE`, `ISSUE`, `WAIT`.
  - `IDLE`: if not empty, go to `ISSUE`.
  - `ISSUE`: `mem_req_valid_o=1`, `mem_req_o` = head. On `mem_req_ready_i`, pop the head. For a write, go to `IDLE`. For a read, latch `cache_id` into `pend_id` and go to `WAIT`.
  - `WAIT`: on `mem_rsp_valid_i`, register `rsp_line_o <= mem_rsp_line_i`, pulse the rsp_valid selected by `pend_id` on the next cycle, then go to `IDLE`.
- **Ordering:** strict FIFO; at most one read outstanding.
- **Simultaneous push and pop:** `count` unchanged; both pointers advance.
- **Push when full:** impossible, because ready is low.
- **Pop when empty:** impossible (FSM only leaves `IDLE` when not empty).
- **`mem_rsp_valid_i` outside `WAIT`:** ignored.
- **`mem_req_o` stability:** stable throughout `ISSUE` until the handshake, since head only moves on pop.

## Timing
- **Reset (`rsn_i==0` at an edge):** FSM←`IDLE`, pointers and `count`←0, `last_grant`←ICACHE, `pend_id`←ICACHE, `rsp_line_o`←0, `ic_rsp_valid_o`/`dc_rsp_valid_o`←0. Ready outputs are forced 0 while reset is asserted.
  - `mem_req_valid_o` is 0 in `IDLE`.
  - Reset mid-transaction drops the FIFO contents and any pending response.
- **Empty-FIFO request latency:** accepted in cycle T (write at edge T). `IDLE` sees non-empty in T+1. `mem_req_valid_o` is high in T+2.
- **Read return:** `mem_rsp_valid_i` in cycle R → rsp_valid pulse and `rsp_line_o` in R+1, exactly one cycle. FSM is in `IDLE` in R+1; next issue earliest R+2.
- **Back-to-back writes with `mem_req_ready_i` tied high:** one issue every 2 cycles.

## Test plan
- **Single icache read:** `ic_req_i=1`, addr=0x100, rd=1, idle system → `ic_ready_o=1` same cycle; `mem_req_valid_o` 2 cycles later with addr 0x100, `cache_id`=ICACHE. Respond with line 0xDEADBEEF_… → `ic_rsp_valid_o` one-cycle pulse next cycle with that line; `dc_rsp_valid_o` stays 0.
- **Simultaneous requests, 4 cycles, both valid, distinct addrs:** grants alternate D,I,D,I. Memory sees the same order. Responses route by id.
- **Fill to full:** hold `mem_req_ready_i=0`, push 16 dcache writes → `count=16`, ready 0 on the 17th. Release ready → 16 writes issue in order. No rsp pulses.
- **Wrap-around:** push/pop 40 mixed requests, so pointers wrap twice → memory order equals acceptance order. `count` ends 0.
- **Push and pop same cycle at `count=1`:** `count` stays 1, and the new entry is issued next.
- **Reset mid-`WAIT`:** assert `rsn_i=0` for one cycle while a read is outstanding, then deliver `mem_rsp_valid_i` → no rsp pulse, FIFO empty, all outputs at reset values.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// -----------------------------------------------------------------------------
// segre_pkg / segre_mem_arbiter
//
// Purpose:
//   Merges line-granular memory requests from the instruction cache and the
//   data cache onto the single main-memory port. Accepted requests are queued
//   in a FIFO and sent to memory one at a time, in strict order. Only one read
//   is in flight at a time. Its response line is returned to the cache that
//   issued it. Writes are posted and get no response.
//
// Ports:
//   clk_i, rsn_i                       clock, synchronous active-low reset
//   ic_req_i / ic_req_data_i           icache request valid / payload
//   ic_ready_o                         icache request accepted this cycle
//   dc_req_i / dc_req_data_i           dcache request valid / payload
//   dc_ready_o                         dcache request accepted this cycle
//   mem_req_valid_o / mem_req_o        request at the head of the FIFO
//   mem_req_ready_i                    memory accepts the request
//   mem_rsp_valid_i / mem_rsp_line_i   memory read data
//   ic_rsp_valid_o / dc_rsp_valid_o    one-cycle response pulse per cache
//   rsp_line_o                         registered response line
// -----------------------------------------------------------------------------
package segre_pkg;
    localparam int ARB_BUF_SIZE         = 16;
    localparam int ARB_PTR_SIZE         = 4;
    localparam int CACHE_LINE_SIZE_BITS = 128;
    localparam int ADDR_SIZE            = 32;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } cache_id_t;

    typedef struct packed {
        logic [ADDR_SIZE-1:0]            addr;
        logic                            rd;
        logic                            wr;
        logic [CACHE_LINE_SIZE_BITS-1:0] data;
        cache_id_t                       cache_id;
    } cache_mem_req_t;
endpackage

module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int BUF_SIZE  = ARB_BUF_SIZE,
    parameter int PTR_SIZE  = ARB_PTR_SIZE,
    parameter int LINE_BITS = CACHE_LINE_SIZE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ic_req_i,
    input  cache_mem_req_t       ic_req_data_i,
    output logic                 ic_ready_o,
    input  logic                 dc_req_i,
    input  cache_mem_req_t       dc_req_data_i,
    output logic                 dc_ready_o,
    output logic                 mem_req_valid_o,
    output cache_mem_req_t       mem_req_o,
    input  logic                 mem_req_ready_i,
    input  logic                 mem_rsp_valid_i,
    input  logic [LINE_BITS-1:0] mem_rsp_line_i,
    output logic                 ic_rsp_valid_o,
    output logic                 dc_rsp_valid_o,
    output logic [LINE_BITS-1:0] rsp_line_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [PTR_SIZE:0]   FULL_COUNT = (PTR_SIZE+1)'(BUF_SIZE);
    localparam logic [PTR_SIZE-1:0] PTR_ONE    = PTR_SIZE'(1);
    localparam logic [PTR_SIZE:0]   CNT_ONE    = (PTR_SIZE+1)'(1);

    state_t               state_reg;
    logic [PTR_SIZE-1:0]  head_reg;
    logic [PTR_SIZE-1:0]  tail_reg;
    logic [PTR_SIZE:0]    count_reg;
    cache_id_t            last_grant_reg;
    cache_id_t            pend_id_reg;
    logic                 mem_req_valid_reg;
    logic                 ic_rsp_valid_reg;
    logic                 dc_rsp_valid_reg;
    logic [LINE_BITS-1:0] rsp_line_reg;
    cache_mem_req_t       req_reg;

    // Request storage. No reset so it maps onto RAM; entries are only read
    // once count says they were written.
    cache_mem_req_t       buf_mem [BUF_SIZE];

    logic                 full;
    logic                 empty;
    logic                 ic_grant;
    logic                 dc_grant;
    logic                 push;
    logic                 pop;
    cache_mem_req_t       push_entry;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    // Round-robin on a tie: the side that did not win last time goes first.
    assign ic_grant = ic_req_i && (!dc_req_i || (last_grant_reg == DCACHE));
    assign dc_grant = dc_req_i && (!ic_req_i || (last_grant_reg == ICACHE));

    assign ic_ready_o = rsn_i && !full && ic_grant;
    assign dc_ready_o = rsn_i && !full && dc_grant;

    assign push = ic_ready_o || dc_ready_o;
    assign pop  = (state_reg == ISSUE) && mem_req_ready_i;

    // The stored cache_id always names the port the request arrived on, so
    // responses go back to the correct cache whatever the requester supplied.
    always_comb begin
        push_entry          = dc_ready_o ? dc_req_data_i : ic_req_data_i;
        push_entry.cache_id = dc_ready_o ? DCACHE : ICACHE;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_mem[tail_reg] <= push_entry;
        end
    end

    // Registered read of the head entry while idle. The head stays put until
    // the pop that ends ISSUE, so the presented request is stable.
    always_ff @(posedge clk_i) begin
        if (state_reg == IDLE) begin
            req_reg <= buf_mem[head_reg];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_reg         <= IDLE;
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            last_grant_reg    <= ICACHE;
            pend_id_reg       <= ICACHE;
            mem_req_valid_reg <= 1'b0;
            ic_rsp_valid_reg  <= 1'b0;
            dc_rsp_valid_reg  <= 1'b0;
            rsp_line_reg      <= '0;
        end else begin
            ic_rsp_valid_reg <= 1'b0;
            dc_rsp_valid_reg <= 1'b0;

            if (push) begin
                tail_reg       <= tail_reg + PTR_ONE;
                last_grant_reg <= dc_ready_o ? DCACHE : ICACHE;
            end
            if (pop) begin
                head_reg <= head_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_ONE;
            end

            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        state_reg         <= ISSUE;
                        mem_req_valid_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_reg <= 1'b0;
                        if (req_reg.rd) begin
                            pend_id_reg <= req_reg.cache_id;
                            state_reg   <= WAIT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        rsp_line_reg     <= mem_rsp_line_i;
                        ic_rsp_valid_reg <= (pend_id_reg == ICACHE);
                        dc_rsp_valid_reg <= (pend_id_reg == DCACHE);
                        state_reg        <= IDLE;
                    end
                end
                default: begin
                    state_reg         <= IDLE;
                    mem_req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid_o = mem_req_valid_reg;
    assign mem_req_o       = req_reg;
    assign ic_rsp_valid_o  = ic_rsp_valid_reg;
    assign dc_rsp_valid_o  = dc_rsp_valid_reg;
    assign rsp_line_o      = rsp_line_reg;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_segre_mem_arbiter
//
// Drives the two cache request ports and a small memory model. Each accepted
// request is pushed to an expected-request queue that holds the bench's own
// grant decision. A negedge monitor pops that queue at every memory handshake.
// Read responses go to an expected-response queue and are checked
// cycle-exactly against the rsp pulses.
// -----------------------------------------------------------------------------
module tb_segre_mem_arbiter;
    import segre_pkg::*;

    typedef struct {
        cache_id_t    id;
        logic [127:0] line;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rsn;
    logic           ic_req;
    cache_mem_req_t ic_req_data;
    logic           ic_ready;
    logic           dc_req;
    cache_mem_req_t dc_req_data;
    logic           dc_ready;
    logic           mem_req_valid;
    cache_mem_req_t mem_req;
    logic           mem_req_ready;
    logic           mem_rsp_valid;
    logic [127:0]   mem_rsp_line;
    logic           ic_rsp_valid;
    logic           dc_rsp_valid;
    logic [127:0]   rsp_line;

    int checks = 0;
    int errors = 0;

    // Bench model state.
    cache_mem_req_t exp_req_q[$];
    rsp_t           exp_rsp_q[$];
    int             model_count = 0;
    cache_id_t      model_last  = ICACHE;
    bit             rd_pending  = 0;
    int             rd_wait     = 0;
    rsp_t           rd_exp;
    bit             rsp_due     = 0;
    bit             rsp_driving = 0;
    bit             mem_auto    = 1;

    always #5 clk = ~clk;

    segre_mem_arbiter dut (
        .clk_i           (clk),
        .rsn_i           (rsn),
        .ic_req_i        (ic_req),
        .ic_req_data_i   (ic_req_data),
        .ic_ready_o      (ic_ready),
        .dc_req_i        (dc_req),
        .dc_req_data_i   (dc_req_data),
        .dc_ready_o      (dc_ready),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_o       (mem_req),
        .mem_req_ready_i (mem_req_ready),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_line_i  (mem_rsp_line),
        .ic_rsp_valid_o  (ic_rsp_valid),
        .dc_rsp_valid_o  (dc_rsp_valid),
        .rsp_line_o      (rsp_line)
    );

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        return {32'hDEADBEEF, a, ~a, 32'h0BADF00D ^ a};
    endfunction

    function automatic cache_mem_req_t mk_req(input logic [31:0] a, input bit rd, input cache_id_t id);
        cache_mem_req_t r;
        r.addr     = a;
        r.rd       = rd;
        r.wr       = !rd;
        r.data     = {a, 32'h5A5A0000 | a, ~a, a ^ 32'h12345678};
        r.cache_id = id;
        return r;
    endfunction

    function automatic cache_mem_req_t rand_req();
        cache_mem_req_t r;
        r.addr     = $urandom() & 32'hFFFF_FFF0;
        r.rd       = 1'($urandom_range(0, 1));
        r.wr       = !r.rd;
        r.data     = {$urandom(), $urandom(), $urandom(), $urandom()};
        r.cache_id = cache_id_t'(1'($urandom_range(0, 1)));
        return r;
    endfunction

    // Memory side monitor / model.
    cache_mem_req_t mon_req;
    rsp_t           mon_rsp;
    always @(negedge clk) begin
        if (rsn === 1'b1) begin
            if (ic_rsp_valid || dc_rsp_valid || rsp_due) begin
                checks++;
                if (!rsp_due) begin
                    errors++;
                    $display("FAIL rsp_unexpected ic=%0b dc=%0b required no pulse", ic_rsp_valid, dc_rsp_valid);
                end else begin
                    mon_rsp = exp_rsp_q.pop_front();
                    if (ic_rsp_valid !== (mon_rsp.id == ICACHE) || dc_rsp_valid !== (mon_rsp.id == DCACHE)
                        || rsp_line !== mon_rsp.line) begin
                        errors++;
                        $display("FAIL rsp_route ic=%0b dc=%0b line=%h required id=%0d line=%h",
                                 ic_rsp_valid, dc_rsp_valid, rsp_line, mon_rsp.id, mon_rsp.line);
                    end
                end
            end
            rsp_due = 0;
            if (rsp_driving) begin
                mem_rsp_valid = 1'b0;
                rsp_driving   = 0;
            end
            if (mem_req_valid && mem_req_ready) begin
                checks++;
                model_count--;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected addr=%h required nothing issued", mem_req.addr);
                end else begin
                    mon_req = exp_req_q.pop_front();
                    if (mem_req !== mon_req) begin
                        errors++;
                        $display("FAIL req_order addr=%h rd=%0b id=%0d required addr=%h rd=%0b id=%0d",
                                 mem_req.addr, mem_req.rd, mem_req.cache_id,
                                 mon_req.addr, mon_req.rd, mon_req.cache_id);
                    end
                    if (mon_req.rd) begin
                        rd_pending  = 1;
                        rd_wait     = 2;
                        rd_exp.id   = mon_req.cache_id;
                        rd_exp.line = mem_line(mon_req.addr);
                    end
                end
            end
            if (rd_pending && mem_auto) begin
                if (rd_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_line  = rd_exp.line;
                    rsp_driving   = 1;
                    rsp_due       = 1;
                    exp_rsp_q.push_back(rd_exp);
                    rd_pending    = 0;
                end else begin
                    rd_wait--;
                end
            end
        end
    end

    task automatic clear_model();
        exp_req_q.delete();
        exp_rsp_q.delete();
        model_count = 0;
        model_last  = ICACHE;
        rd_pending  = 0;
        rsp_due     = 0;
        rsp_driving = 0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rsn = 1'b0; ic_req = 1'b0; dc_req = 1'b0; mem_req_ready = 1'b0;
        clear_model();
        mem_auto = 1;
        @(posedge clk); #1;
        rsn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ic_req = 1'b0;
            dc_req = 1'b0;
        end
    endtask

    // Drives one cycle of requests, returns observed and modelled grants and
    // records the modelled acceptance in the expected-request queue.
    task automatic drive_req(input bit ic_v, input cache_mem_req_t ic_d, input bit dc_v,
                             input cache_mem_req_t dc_d, input bit mrdy,
                             output bit got_ic, output bit got_dc, output bit exp_ic, output bit exp_dc);
        cache_mem_req_t e;
        @(posedge clk); #1;
        ic_req = ic_v; ic_req_data = ic_d;
        dc_req = dc_v; dc_req_data = dc_d;
        mem_req_ready = mrdy;
        #1;
        got_ic = ic_ready;
        got_dc = dc_ready;
        exp_ic = 0;
        exp_dc = 0;
        if (model_count < 16) begin
            if (ic_v && (!dc_v || model_last == DCACHE)) exp_ic = 1;
            else if (dc_v) exp_dc = 1;
        end
        if (exp_ic) begin
            e = ic_d; e.cache_id = ICACHE;
            exp_req_q.push_back(e); model_last = ICACHE; model_count++;
        end
        if (exp_dc) begin
            e = dc_d; e.cache_id = DCACHE;
            exp_req_q.push_back(e); model_last = DCACHE; model_count++;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_req_q.size() == 0 && exp_rsp_q.size() == 0 && !rd_pending && !rsp_due && !rsp_driving) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rsn = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_line = '0;
        ic_req = 1'b1; ic_req_data = mk_req(32'h40, 1, ICACHE);
        dc_req = 1'b1; dc_req_data = mk_req(32'h80, 1, DCACHE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ic_ready !== 1'b0) begin errors++; $display("FAIL reset_ic_ready got=%0b required=0", ic_ready); end
        checks++; if (dc_ready !== 1'b0) begin errors++; $display("FAIL reset_dc_ready got=%0b required=0", dc_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%0b required=0", mem_req_valid); end
        checks++; if (ic_rsp_valid !== 1'b0 || dc_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid got=%0b%0b required=00", ic_rsp_valid, dc_rsp_valid); end
        checks++; if (rsp_line !== '0) begin errors++; $display("FAIL reset_rsp_line got=%h required=0", rsp_line); end
        @(posedge clk); #1;
        rsn = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
        clear_model();
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_mem_valid got=%0b required=0", mem_req_valid); end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        bit gi, gd, ei, ed, seen;
        do_reset();
        drive_req(1, mk_req(32'h100, 1, DCACHE), 0, mk_req(32'h0, 0, DCACHE), 1, gi, gd, ei, ed);
        checks++; if (gi !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL single_ready got=%0b%0b required=10", gi, gd); end
        idle(1);
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 got=%0b required=0", mem_req_valid); end
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_req.addr !== 32'h100 || mem_req.cache_id !== ICACHE) begin
            errors++; $display("FAIL single_issue valid=%0b addr=%h id=%0d required 1 100 0", mem_req_valid, mem_req.addr, mem_req.cache_id); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ic_rsp_valid || dc_rsp_valid) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL single_rsp_timeout got=none required=ic pulse");
        end else if (ic_rsp_valid !== 1'b1 || dc_rsp_valid !== 1'b0 || rsp_line !== mem_line(32'h100)) begin
            errors++; $display("FAIL single_rsp ic=%0b dc=%0b line=%h required 1 0 %h", ic_rsp_valid, dc_rsp_valid, rsp_line, mem_line(32'h100));
        end
        @(negedge clk);
        checks++; if (ic_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_len got=%0b required=0", ic_rsp_valid); end
        $display("test_single_read done");
    endtask

    task automatic test_simultaneous();
        bit gi, gd, ei, ed, ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_req(1, mk_req(32'h1000 + 32'(i * 16), 1, ICACHE), 1, mk_req(32'h2000 + 32'(i * 16), 1, ICACHE), 1, gi, gd, ei, ed);
            checks++;
            if (gd !== (i % 2 == 0) || gi !== (i % 2 == 1)) begin
                errors++; $display("FAIL rr_grant cycle=%0d got ic=%0b dc=%0b required dc=%0b", i, gi, gd, (i % 2 == 0));
            end
        end
        idle(1);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_drain got=timeout required=drained"); end
        $display("test_simultaneous done");
    endtask

    task automatic test_fill_full();
        bit gi, gd, ei, ed, ok;
        int hs, last_c, gap_bad, c;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive_req(0, mk_req(32'h0, 0, ICACHE), 1, mk_req(32'h3000 + 32'(i * 16), 0, ICACHE), 0, gi, gd, ei, ed);
            checks++;
            if (gd !== (i < 16)) begin
                errors++; $display("FAIL fill_ready push=%0d got=%0b required=%0b", i, gd, (i < 16));
            end
        end
        idle(1);
        mem_req_ready = 1'b1;
        hs = 0; last_c = 0; gap_bad = 0; c = 0;
        while (c < 100 && hs < 16) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                if (hs > 0 && c - last_c != 2) gap_bad++;
                last_c = c;
                hs++;
            end
            c++;
        end
        checks++; if (hs != 16) begin errors++; $display("FAIL fill_drain_count got=%0d required=16", hs); end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_spacing got=%0d bad gaps required=0", gap_bad); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_drain got=timeout required=drained"); end
        $display("test_fill_full done");
    endtask

    task automatic test_wrap();
        bit gi, gd, ei, ed, ok;
        int accepted, cyc;
        do_reset();
        accepted = 0; cyc = 0;
        while (accepted < 40 && cyc < 600) begin
            drive_req(1'($urandom_range(0, 1)), rand_req(), 1'($urandom_range(0, 1)), rand_req(),
                      ($urandom_range(0, 3) != 0), gi, gd, ei, ed);
            checks++;
            if (gi !== ei || gd !== ed) begin
                errors++; $display("FAIL wrap_grant cycle=%0d got ic=%0b dc=%0b required ic=%0b dc=%0b", cyc, gi, gd, ei, ed);
            end
            accepted += int'(ei) + int'(ed);
            cyc++;
        end
        idle(1);
        mem_req_ready = 1'b1;
        wait_drain(ok);
        checks++; if (!ok || accepted < 40) begin errors++; $display("FAIL wrap_drain accepted=%0d drained=%0b required 40 1", accepted, ok); end
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%0b required=0", mem_req_valid); end
        $display("test_wrap done accepted=%0d", accepted);
    endtask

    task automatic test_push_pop_same();
        bit gi, gd, ei, ed;
        do_reset();
        drive_req(0, mk_req(32'h0, 0, ICACHE), 1, mk_req(32'h4A0, 0, ICACHE), 0, gi, gd, ei, ed);
        idle(2);
        drive_req(1, mk_req(32'h4B0, 0, DCACHE), 0, mk_req(32'h0, 0, ICACHE), 1, gi, gd, ei, ed);
        checks++; if (gi !== 1'b1) begin errors++; $display("FAIL pp_ready got=%0b required=1", gi); end
        idle(1);
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL pp_idle got=%0b required=0", mem_req_valid); end
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_req.addr !== 32'h4B0) begin
            errors++; $display("FAIL pp_next valid=%0b addr=%h required 1 4b0", mem_req_valid, mem_req.addr); end
        repeat (3) @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL pp_count got=%0b required=0", mem_req_valid); end
        $display("test_push_pop_same done");
    endtask

    task automatic test_reset_mid_wait();
        bit gi, gd, ei, ed, hs;
        do_reset();
        mem_auto = 0;
        drive_req(1, mk_req(32'h300, 1, ICACHE), 0, mk_req(32'h0, 0, ICACHE), 1, gi, gd, ei, ed);
        idle(1);
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin hs = 1; break; end
        end
        checks++; if (!hs) begin errors++; $display("FAIL rmw_issue got=timeout required=handshake"); end
        @(posedge clk); #1;
        rsn = 1'b0;
        clear_model();
        @(posedge clk); #1;
        rsn = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_line  = mem_line(32'h300);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ic_rsp_valid !== 1'b0 || dc_rsp_valid !== 1'b0 || rsp_line !== '0 || mem_req_valid !== 1'b0) begin
                errors++; $display("FAIL rmw_quiet cycle=%0d ic=%0b dc=%0b line=%h valid=%0b required all 0",
                                   i, ic_rsp_valid, dc_rsp_valid, rsp_line, mem_req_valid);
            end
        end
        mem_auto = 1;
        $display("test_reset_mid_wait done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fill_full();
        test_wrap();
        test_push_pop_same();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
